vram_line_arbiter: RTL
======================

VRAM_LINE_ARBITER -- requirements
Module: vram_line_arbiter

Interface
REQ-001 Parameter WORDS, default 40, meaning 16-bit words per visible line (640 px, 1 bpp).
REQ-002 Parameter ADDR_W, default 15, meaning framebuffer word-address width (480*40 = 19200 words).
REQ-003 Parameter ROWS, default 480, meaning visible lines per frame.
REQ-004 px_clk  input  1  pixel clock; all logic on rising edge.
REQ-005 reset  input  1  reset, synchronous, active-high.
REQ-006 hsync  input  1  active-low horizontal sync from the sync generator.
REQ-007 activevideo  input  1  high in the visible region.
REQ-008 x_px  input  10  current visible pixel column.
REQ-009 y_px  input  10  current visible row; values >= ROWS denote vertical blanking.
REQ-010 wr_req  input  1  writer requests one framebuffer word write.
REQ-011 wr_addr  input  ADDR_W  writer word address.
REQ-012 wr_data  input  16  writer word data.
REQ-013 wr_ack  output  1  one-cycle pulse: the write was issued this cycle.
REQ-014 ram_addr  output  ADDR_W  single-port RAM address.
REQ-015 ram_we  output  1  RAM write enable.
REQ-016 ram_wdata  output  16  RAM write data.
REQ-017 ram_rdata  input  16  RAM read data, valid exactly 1 cycle after the address is presented.
REQ-018 pixel  output  1  registered pixel for the display.
REQ-019 overrun  output  1  sticky flag: a fetch trigger arrived while a fetch was still in progress.

Function
REQ-020 Fetch trigger: the cycle in which hsync is low and was high in the previous cycle (falling edge), qualified by y_px < ROWS; the row fetched is the y_px value sampled on the trigger cycle.
REQ-021 FSM states: IDLE, FETCH, DRAIN.
REQ-022 IDLE->FETCH on trigger, word counter cleared to 0; trigger has priority over a simultaneous wr_req.
REQ-023 FETCH: one read per cycle, ram_addr = row*40 + word (shift-add, ADDR_W bits, no multiplier), ram_we = 0; word increments 0..WORDS-1; FETCH->DRAIN after word WORDS-1 is issued.
REQ-024 DRAIN: lasts one cycle to capture the final read, then returns to IDLE; a fetch occupies exactly WORDS+1 cycles from trigger to IDLE.
REQ-025 Read data for word k, returning one cycle after issue, is written into line-buffer entry k.
REQ-026 Writer handshake: in IDLE with wr_req = 1 and no trigger, drive ram_addr = wr_addr, ram_we = 1, ram_wdata = wr_data, and pulse wr_ack the same cycle; at most one write per cycle; back-to-back writes are allowed.
REQ-027 In FETCH and DRAIN, wr_ack = 0 and ram_we = 0; the writer holds wr_req, wr_addr and wr_data until it sees wr_ack.
REQ-028 A trigger in FETCH or DRAIN is ignored and sets overrun; overrun clears only on reset.
REQ-029 pixel = linebuf[x_px[9:4]] bit (15 - x_px[3:0]) when activevideo = 1, else 0; registered, 1-cycle latency.
REQ-030 Triggers with y_px >= ROWS (blanking wrap values) start no fetch; line-buffer contents are held.

Reset
REQ-031 On reset: FSM = IDLE, word counter = 0, wr_ack = 0, ram_we = 0, ram_addr = 0, ram_wdata = 0, pixel = 0, overrun = 0, and the hsync edge detector primed high.
REQ-032 Reset during FETCH aborts the fetch immediately; line-buffer contents are not cleared.
REQ-033 Reset overrides any pending wr_req; no write is issued in a reset cycle.

Structure
REQ-034 WORDS, ROWS, ADDR_W defaults and the FSM state encoding SHALL live in shared package vga_pkg.
REQ-035 The line buffer SHALL be a sub-module vga_linebuf (WORDS x 16, one synchronous write port, one asynchronous read port).

Verification
REQ-036 Trigger with y_px = 0 -> reads of addresses 0..39 on consecutive cycles, IDLE after 41 cycles.
REQ-037 Trigger with y_px = 479 -> first ram_addr = 19160, last = 19199.
REQ-038 wr_req raised on the trigger cycle, wr_addr = 100, wr_data = 0xA5A5 -> wr_ack is first asserted 41 cycles later, with ram_we = 1 and ram_addr = 100.
REQ-039 RAM word 0 of row 5 = 0x8001, display row 5 -> pixel = 1 at x_px 0 and 15, pixel = 0 at x_px 1..14, each one cycle after x_px is presented.
REQ-040 Two triggers 20 cycles apart -> overrun = 1 and stays 1; the second fetch is not started.
REQ-041 Reset asserted at word 10 of a fetch -> next cycle: IDLE, ram_we = 0, pixel = 0; next valid trigger restarts at word 0.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared defaults and FSM encoding for the VGA line-fetch path.
package vga_pkg;

  localparam int WORDS_DEF  = 40;
  localparam int ROWS_DEF   = 480;
  localparam int ADDR_W_DEF = 15;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/vga_linebuf.sv
// One visible line of 16-bit words: synchronous write, asynchronous read.
module vga_linebuf #(
  parameter int WORDS = 40
) (
  input  logic        px_clk,
  input  logic        we,
  input  logic [5:0]  waddr,
  input  logic [15:0] wdata,
  input  logic [5:0]  raddr,
  output logic [15:0] rdata
);

  localparam logic [5:0] LIMIT = 6'(WORDS);

  logic [15:0] mem [WORDS];

  always_ff @(posedge px_clk) begin
    if (we && (waddr < LIMIT)) mem[waddr] <= wdata;
  end

  // Columns beyond the line width read as background.
  assign rdata = (raddr < LIMIT) ? mem[raddr] : 16'h0000;

endmodule

// File: rtl/vram_line_arbiter.sv
// Shares a single-port framebuffer RAM between a word writer and the
// per-line display fetch, and serialises the fetched line into pixels.
module vram_line_arbiter
  import vga_pkg::*;
#(
  parameter int WORDS  = WORDS_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int ROWS   = ROWS_DEF
) (
  input  logic              px_clk,
  input  logic              reset,
  input  logic              hsync,
  input  logic              activevideo,
  input  logic [9:0]        x_px,
  input  logic [9:0]        y_px,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [15:0]       wr_data,
  output logic              wr_ack,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [15:0]       ram_wdata,
  input  logic [15:0]       ram_rdata,
  output logic              pixel,
  output logic              overrun,
  output state_t            dbg_state
);

  localparam int              WW        = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [WW-1:0]   LAST_WORD = WW'(WORDS - 1);
  localparam logic [9:0]      ROWS_L    = 10'(ROWS);

  state_t          state_q, state_d;
  logic [WW-1:0]   word_q, word_d;
  logic [9:0]      row_q, row_d;
  logic            rd_pend_q, rd_pend_d;
  logic [WW-1:0]   rd_word_q, rd_word_d;
  logic            hs_prev_q, hs_prev_d;
  logic            overrun_q, overrun_d;
  logic            pixel_q, pixel_d;

  logic            trig;
  logic [9:0]      row_sel;
  logic [ADDR_W-1:0] row_ext, rd_addr;
  logic [15:0]     lb_rdata;
  logic            lb_we;

  assign trig = !hsync && hs_prev_q && (y_px < ROWS_L);

  // Word 0 is issued in the trigger cycle itself, straight from y_px, so a
  // fetch spends WORDS+1 cycles away from IDLE counting the trigger.
  assign row_sel = (state_q == ST_IDLE) ? y_px : row_q;
  assign row_ext = ADDR_W'(row_sel);
  assign rd_addr = (row_ext << 5) + (row_ext << 3) + ADDR_W'(word_q);

  // Writer handshake: wr_req/wr_addr/wr_data form a request that must stay
  // stable until wr_ack; wr_ack is the ready strobe and the write happens in
  // exactly the cycle where wr_req && wr_ack, so one ack means one write.
  always_comb begin
    state_d   = state_q;
    word_d    = word_q;
    row_d     = row_q;
    rd_pend_d = 1'b0;
    rd_word_d = word_q;
    hs_prev_d = hsync;
    overrun_d = overrun_q;
    ram_addr  = '0;
    ram_we    = 1'b0;
    ram_wdata = 16'h0000;
    wr_ack    = 1'b0;
    pixel_d   = activevideo ? lb_rdata[4'd15 - x_px[3:0]] : 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (trig) begin
          ram_addr  = rd_addr;
          row_d     = y_px;
          rd_pend_d = 1'b1;
          rd_word_d = word_q;
          if (word_q == LAST_WORD) begin
            state_d = ST_DRAIN;
          end else begin
            state_d = ST_FETCH;
            word_d  = word_q + 1'b1;
          end
        end else if (wr_req) begin
          ram_addr  = wr_addr;
          ram_we    = 1'b1;
          ram_wdata = wr_data;
          wr_ack    = 1'b1;
        end
      end
      ST_FETCH: begin
        ram_addr  = rd_addr;
        rd_pend_d = 1'b1;
        rd_word_d = word_q;
        if (word_q == LAST_WORD) begin
          state_d = ST_DRAIN;
          word_d  = '0;
        end else begin
          word_d = word_q + 1'b1;
        end
      end
      ST_DRAIN: begin
        state_d = ST_IDLE;
        word_d  = '0;
      end
      default: begin
        state_d = ST_IDLE;
        word_d  = '0;
      end
    endcase

    if (trig && (state_q != ST_IDLE)) overrun_d = 1'b1;

    if (reset) begin
      state_d   = ST_IDLE;
      word_d    = '0;
      rd_pend_d = 1'b0;
      hs_prev_d = 1'b1;
      overrun_d = 1'b0;
      pixel_d   = 1'b0;
      ram_addr  = '0;
      ram_we    = 1'b0;
      ram_wdata = 16'h0000;
      wr_ack    = 1'b0;
    end
  end

  always_ff @(posedge px_clk) begin
    state_q   <= state_d;
    word_q    <= word_d;
    row_q     <= row_d;
    rd_pend_q <= rd_pend_d;
    rd_word_q <= rd_word_d;
    hs_prev_q <= hs_prev_d;
    overrun_q <= overrun_d;
    pixel_q   <= pixel_d;
  end

  // A read returning in a reset cycle belongs to the aborted fetch.
  assign lb_we = rd_pend_q && !reset;

  vga_linebuf #(.WORDS(WORDS)) u_linebuf (
    .px_clk (px_clk),
    .we     (lb_we),
    .waddr  (6'(rd_word_q)),
    .wdata  (ram_rdata),
    .raddr  (x_px[9:4]),
    .rdata  (lb_rdata)
  );

  assign pixel     = pixel_q;
  assign overrun   = overrun_q;
  assign dbg_state = state_q;

endmodule
